mem_initiator: RTL and testbench
================================

// Module: mem_initiator
// PURPOSE
// Initiator side of mem_if: drives the memory's wr/rd/addr/data pins and collects rddata/rddatavalid.
// Accepts read/write requests on a valid/ready port and issues at most one per cycle, never rd and wr together.
// Returns read data in issue order on a valid/ready response port, via a credit-limited response FIFO.
// Sits between a test/DMA-style request source and the mem responder; the responder has fixed 1-cycle read latency.
// PARAMETERS
// RSP_DEPTH  4  response FIFO entries (>=2); also the bound on reads in flight plus buffered responses
// DWIDTH/AWIDTH are not parameters; they come from my_params_pkg.
// PORTS
// clk_i        in   1       clock, all logic on posedge
// rst_ni       in   1       asynchronous active-low reset
// mem_if       if   -       mem_if instance, initiator side: drives wr, rd, addr, data; samples rddata, rddatavalid
// req_valid_i  in   1       request present
// req_ready_o  out  1       request accepted when valid&&ready at posedge
// req_write_i  in   1       1 = write, 0 = read
// req_addr_i   in   AWIDTH  request address
// req_wdata_i  in   DWIDTH  write data, ignored for reads
// rsp_valid_o  out  1       read data available
// rsp_ready_i  in   1       consumer takes rsp_data_o when valid&&ready at posedge
// rsp_data_o   out  DWIDTH  read data, in request order
// err_o        out  1       sticky: unexpected rddatavalid (no read outstanding); cleared only by reset
// rd_cnt_o     out  32      reads issued, wraps at 2^32
// wr_cnt_o     out  32      writes issued, wraps at 2^32
// BEHAVIOUR
// - Reset (async assert, sync release) forces these outputs to 0: mem_if.wr, mem_if.rd, mem_if.addr, mem_if.data,
//   req_ready_o, rsp_valid_o, rsp_data_o, err_o, rd_cnt_o and wr_cnt_o. The FIFO, in-flight count and issue register also clear to 0.
// - mem_if.wr, mem_if.rd, mem_if.addr and mem_if.data are registered outputs (issue register).
//   A request accepted at edge N drives them for the cycle after edge N, so the memory acts on it at edge N+1.
// - With no accept at an edge, wr and rd go low. addr and data hold their last value.
// - Read latency: accepted at edge N -> rddatavalid after N+1 -> written into FIFO at N+2 -> rsp_valid_o after N+2.
//   Minimum accept-to-response latency is 2 cycles; back-to-back reads sustain 1 per cycle.
// - inflight = reads in the issue register plus reads awaiting rddatavalid (0..2).
//   The in-flight count increments when a read is accepted and decrements on a counted rddatavalid.
// - Credit rule: req_ready_o = (fifo_count + inflight) < RSP_DEPTH, for reads and writes alike.
//   This keeps ready independent of req_write_i. It may use current-cycle counts, but must not depend on req_valid_i.
// - Writes return no response. A read issued the cycle after a write to the same address returns the new data.
// - rddatavalid=1 with inflight==0: the data is dropped and err_o is set.
//   Exception: the first cycle after reset release, where it is dropped silently (the responder has no reset).
// - FIFO push (rddatavalid) and pop (rsp_valid_o && rsp_ready_i) at the same edge: count is unchanged, order is preserved.
//   Because of the credit rule, a push never sees a full FIFO. Assert this in simulation.
// - Pop from an empty FIFO cannot occur, since rsp_valid_o = !empty. rsp_data_o is the FIFO head, stable while valid && !ready.
// - rd_cnt_o and wr_cnt_o increment at the accept edge. Any in-flight read is lost on reset, and no response is produced for it.
// STRUCTURE
// - my_params_pkg: existing DWIDTH/AWIDTH, plus typedef struct packed {logic write; logic [AWIDTH-1:0] addr;
//   logic [DWIDTH-1:0] data;} mem_req_t, which holds the issue register contents.
// - Sub-module rsp_fifo #(WIDTH=DWIDTH, DEPTH=RSP_DEPTH): a synchronous FIFO.
//   It is built from a register array with wrap-around rd/wr pointers and a $clog2(DEPTH+1)-bit count. Its ports are
//   clk_i, rst_ni, push, pdata, pop, head, empty, full and count.
// TESTING (bench = mem_initiator + mem responder on one mem_if; AWIDTH/DWIDTH from package)
// 1 Write 0xA5 @0x3, then read @0x3 the next cycle -> rsp_data_o=0xA5 valid 2 cycles after read accept; wr_cnt=1, rd_cnt=1.
// 2 8 back-to-back reads of preloaded 0x0..0x7 (data=addr+0x10), rsp_ready=1 -> 8 responses 0x10..0x17 in order, 1/cycle.
// 3 rsp_ready=0, issue 6 reads -> exactly 4 accepted, then req_ready_o=0.
//   Set rsp_ready=1 -> remaining 2 accepted, and all 6 responses arrive in order with no loss.
// 4 Force rddatavalid=1 for one cycle with nothing outstanding -> err_o=1 and stays 1; FIFO count unchanged.
// 5 Assert rst_ni low mid-burst with 2 reads in flight -> all outputs 0 asynchronously.
//   After release: no stale responses and err_o=0, and a new read @0x1 returns the correct data.
// 6 Push and pop on the same edge with FIFO at count 3 -> count remains 3, head advances by one entry.

Source files
------------

// File: rtl/my_params_pkg.sv
// Shared widths and the request record used by the mem_if initiator.
//   AWIDTH / DWIDTH : address and data widths of mem_if
//   mem_req_t       : one issued memory operation (contents of the issue register)
package my_params_pkg;

   localparam int AWIDTH = 8;
   localparam int DWIDTH = 32;

   typedef struct packed {
      logic              write;
      logic [AWIDTH-1:0] addr;
      logic [DWIDTH-1:0] data;
   } mem_req_t;

endpackage

// File: rtl/mem_if.sv
// Memory pin bundle between an initiator and a responder with 1-cycle read latency.
//   wr, rd, addr, data  : initiator -> responder
//   rddata, rddatavalid : responder -> initiator
interface mem_if;
   import my_params_pkg::*;

   logic              wr;
   logic              rd;
   logic [AWIDTH-1:0] addr;
   logic [DWIDTH-1:0] data;
   logic [DWIDTH-1:0] rddata;
   logic              rddatavalid;

   modport initiator (output wr, rd, addr, data, input  rddata, rddatavalid);
   modport responder (input  wr, rd, addr, data, output rddata, rddatavalid);
endinterface

// File: rtl/rsp_fifo.sv
// Synchronous FIFO holding read responses until the consumer takes them.
//   clk_i, rst_ni : clock, async active-low reset (contents, pointers, count clear to 0)
//   push, pdata   : write pdata at the tail
//   pop           : drop the head entry
//   head          : current head entry (0 after reset)
//   empty, full   : occupancy flags
//   count         : number of stored entries
module rsp_fifo #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 4
) (
   input  logic                       clk_i,
   input  logic                       rst_ni,
   input  logic                       push,
   input  logic [WIDTH-1:0]           pdata,
   input  logic                       pop,
   output logic [WIDTH-1:0]           head,
   output logic                       empty,
   output logic                       full,
   output logic [$clog2(DEPTH+1)-1:0] count
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH+1);

   logic [DEPTH-1:0][WIDTH-1:0] mem_q, mem_d;
   logic [PW-1:0]               wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]               rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]               count_q, count_d;
   logic                        do_push, do_pop;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(DEPTH-1)) ? '0 : p + PW'(1);
   endfunction

   assign empty = (count_q == '0);
   assign full  = (count_q == CW'(DEPTH));
   assign count = count_q;
   assign head  = mem_q[rd_ptr_q];

   always_comb begin
      // A push into a full FIFO is only taken when the head leaves at the same edge.
      do_push  = push && (!full || pop);
      do_pop   = pop && !empty;
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (do_push) begin
         mem_d[wr_ptr_q] = pdata;
         wr_ptr_d        = ptr_inc(wr_ptr_q);
      end
      if (do_pop) begin
         rd_ptr_d = ptr_inc(rd_ptr_q);
      end
      count_d = count_q + CW'(do_push) - CW'(do_pop);
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         mem_q    <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

endmodule

// File: rtl/mem_initiator.sv
// Initiator side of mem_if. Takes read/write requests on a valid/ready port, issues
// at most one per cycle through a registered issue stage, and returns read data in
// issue order through a credit-limited response FIFO.
//   clk_i, rst_ni         : clock, async active-low reset
//   mem                   : mem_if initiator modport (wr/rd/addr/data out, rddata/rddatavalid in)
//   req_valid_i/ready_o   : request handshake; req_write_i, req_addr_i, req_wdata_i carry it
//   rsp_valid_o/ready_i   : response handshake; rsp_data_o is the FIFO head
//   err_o                 : sticky, rddatavalid seen with no read outstanding
//   rd_cnt_o, wr_cnt_o    : accepted read / write counts, wrapping
module mem_initiator
   import my_params_pkg::*;
#(
   parameter int RSP_DEPTH = 4
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   mem_if.initiator          mem,
   input  logic              req_valid_i,
   output logic              req_ready_o,
   input  logic              req_write_i,
   input  logic [AWIDTH-1:0] req_addr_i,
   input  logic [DWIDTH-1:0] req_wdata_i,
   output logic              rsp_valid_o,
   input  logic              rsp_ready_i,
   output logic [DWIDTH-1:0] rsp_data_o,
   output logic              err_o,
   output logic [31:0]       rd_cnt_o,
   output logic [31:0]       wr_cnt_o
);

   localparam int CNT_W = $clog2(RSP_DEPTH+1);
   localparam int USE_W = CNT_W + 1;

   mem_req_t         issue_q, issue_d;
   logic             issue_vld_q, issue_vld_d;
   logic [1:0]       inflight_q, inflight_d;
   logic             live_q, live_d;
   logic             err_q, err_d;
   logic [31:0]      rd_cnt_q, rd_cnt_d;
   logic [31:0]      wr_cnt_q, wr_cnt_d;

   logic             accept, rd_accept, wr_accept;
   logic             rdv_counted, rdv_stray, rsp_pop;
   logic [CNT_W-1:0] fifo_count;
   logic             fifo_empty, fifo_full;
   logic [USE_W-1:0] credits_used;

   // Every outstanding read owns a FIFO slot, so a push can never find the FIFO full.
   // live_q keeps ready low during reset and for the first cycle after release.
   always_comb begin
      credits_used = USE_W'(fifo_count) + USE_W'(inflight_q);
      req_ready_o  = live_q && (credits_used < USE_W'(RSP_DEPTH));
      accept       = req_valid_i && req_ready_o;
      rd_accept    = accept && !req_write_i;
      wr_accept    = accept &&  req_write_i;
   end

   // The responder has no reset, so a response to a read lost in reset can still
   // show up in the first cycle after release; that one is dropped without error.
   always_comb begin
      rdv_counted = mem.rddatavalid && (inflight_q != 2'd0);
      rdv_stray   = mem.rddatavalid && (inflight_q == 2'd0) && live_q;
      rsp_pop     = !fifo_empty && rsp_ready_i;
   end

   always_comb begin
      issue_vld_d = accept;
      issue_d     = issue_q;
      if (accept) begin
         issue_d.write = req_write_i;
         issue_d.addr  = req_addr_i;
         issue_d.data  = req_wdata_i;
      end
      inflight_d = inflight_q + 2'(rd_accept) - 2'(rdv_counted);
      live_d     = 1'b1;
      err_d      = err_q | rdv_stray;
      rd_cnt_d   = rd_cnt_q + 32'(rd_accept);
      wr_cnt_d   = wr_cnt_q + 32'(wr_accept);
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         issue_q     <= '0;
         issue_vld_q <= 1'b0;
         inflight_q  <= '0;
         live_q      <= 1'b0;
         err_q       <= 1'b0;
         rd_cnt_q    <= '0;
         wr_cnt_q    <= '0;
      end else begin
         issue_q     <= issue_d;
         issue_vld_q <= issue_vld_d;
         inflight_q  <= inflight_d;
         live_q      <= live_d;
         err_q       <= err_d;
         rd_cnt_q    <= rd_cnt_d;
         wr_cnt_q    <= wr_cnt_d;
      end
   end

   // wr/rd drop when nothing was accepted; addr/data keep the last issued value.
   assign mem.wr   = issue_vld_q &&  issue_q.write;
   assign mem.rd   = issue_vld_q && !issue_q.write;
   assign mem.addr = issue_q.addr;
   assign mem.data = issue_q.data;

   rsp_fifo #(
      .WIDTH (DWIDTH),
      .DEPTH (RSP_DEPTH)
   ) u_fifo (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .push   (rdv_counted),
      .pdata  (mem.rddata),
      .pop    (rsp_pop),
      .head   (rsp_data_o),
      .empty  (fifo_empty),
      .full   (fifo_full),
      .count  (fifo_count)
   );

   assign rsp_valid_o = !fifo_empty;
   assign err_o       = err_q;
   assign rd_cnt_o    = rd_cnt_q;
   assign wr_cnt_o    = wr_cnt_q;

   a_no_push_when_full: assert property (@(posedge clk_i) disable iff (!rst_ni)
      !(rdv_counted && fifo_full));

endmodule

// File: tb/tb_mem_initiator.sv
module tb_mem_initiator;
   import my_params_pkg::*;

   logic              clk = 1'b0;
   logic              rst_ni = 1'b1;
   logic              req_valid_i = 1'b0;
   logic              req_ready_o;
   logic              req_write_i = 1'b0;
   logic [AWIDTH-1:0] req_addr_i = '0;
   logic [DWIDTH-1:0] req_wdata_i = '0;
   logic              rsp_valid_o;
   logic              rsp_ready_i = 1'b0;
   logic [DWIDTH-1:0] rsp_data_o;
   logic              err_o;
   logic [31:0]       rd_cnt_o, wr_cnt_o;

   mem_if bus();

   mem_initiator #(.RSP_DEPTH(4)) dut (
      .clk_i       (clk),
      .rst_ni      (rst_ni),
      .mem         (bus),
      .req_valid_i (req_valid_i),
      .req_ready_o (req_ready_o),
      .req_write_i (req_write_i),
      .req_addr_i  (req_addr_i),
      .req_wdata_i (req_wdata_i),
      .rsp_valid_o (rsp_valid_o),
      .rsp_ready_i (rsp_ready_i),
      .rsp_data_o  (rsp_data_o),
      .err_o       (err_o),
      .rd_cnt_o    (rd_cnt_o),
      .wr_cnt_o    (wr_cnt_o)
   );

   always #5 clk = ~clk;

   // Responder: 1-cycle read latency, no reset. force_rdv injects a stray rddatavalid.
   logic              force_rdv = 1'b0;
   logic [DWIDTH-1:0] mem_arr [0:(1<<AWIDTH)-1];
   always @(posedge clk) begin
      if (bus.wr) mem_arr[bus.addr] <= bus.data;
      bus.rddatavalid <= bus.rd | force_rdv;
      bus.rddata      <= mem_arr[bus.addr];
   end

   // Bench state
   int                n_cmp = 0;
   int                n_bad = 0;
   int                cyc = 0;
   int                n_pop = 0;
   int                first_pop_cyc = -1;
   int                last_pop_cyc = -1;
   logic              acc = 1'b0;
   logic [DWIDTH-1:0] model_mem [0:(1<<AWIDTH)-1];
   logic [DWIDTH-1:0] exp_q [$];

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // One clock: sample handshakes at the negedge, update scoreboard, return 1ns after posedge.
   task automatic tick();
      logic [DWIDTH-1:0] e;
      @(negedge clk);
      acc = 1'b0;
      if (rsp_valid_o && rsp_ready_i) begin
         if (exp_q.size() == 0) begin
            check("rsp_spurious", 64'(rsp_valid_o), 64'd0);
         end else begin
            e = exp_q.pop_front();
            check("rsp_data", 64'(rsp_data_o), 64'(e));
         end
         n_pop++;
         if (first_pop_cyc < 0) first_pop_cyc = cyc;
         last_pop_cyc = cyc;
      end
      if (req_valid_i && req_ready_o) begin
         acc = 1'b1;
         if (req_write_i) model_mem[req_addr_i] = req_wdata_i;
         else             exp_q.push_back(model_mem[req_addr_i]);
      end
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic send(input logic w, input logic [AWIDTH-1:0] a, input logic [DWIDTH-1:0] d);
      req_valid_i = 1'b1;
      req_write_i = w;
      req_addr_i  = a;
      req_wdata_i = d;
      acc = 1'b0;
      for (int i = 0; i < 40 && !acc; i++) tick();
      req_valid_i = 1'b0;
      check("req_accepted", 64'(acc), 64'd1);
   endtask

   task automatic drain(input string tag);
      for (int i = 0; i < 30 && exp_q.size() != 0; i++) tick();
      check({tag, "_drained"}, 64'(exp_q.size()), 64'd0);
      tick();
      tick();
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_wr"},      64'(bus.wr),      64'd0);
      check({tag, "_rd"},      64'(bus.rd),      64'd0);
      check({tag, "_addr"},    64'(bus.addr),    64'd0);
      check({tag, "_data"},    64'(bus.data),    64'd0);
      check({tag, "_ready"},   64'(req_ready_o), 64'd0);
      check({tag, "_rvalid"},  64'(rsp_valid_o), 64'd0);
      check({tag, "_rdata"},   64'(rsp_data_o),  64'd0);
      check({tag, "_err"},     64'(err_o),       64'd0);
      check({tag, "_rd_cnt"},  64'(rd_cnt_o),    64'd0);
      check({tag, "_wr_cnt"},  64'(wr_cnt_o),    64'd0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int nacc;
      int pops0;

      // Reset
      rst_ni = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check_all_zero("reset");
      @(negedge clk);
      rst_ni = 1'b1;
      @(posedge clk);
      #1;

      // 1: write then read-after-write, 2-cycle response latency
      rsp_ready_i = 1'b0;
      send(1'b1, 8'h03, 32'hA5);
      send(1'b0, 8'h03, 32'h0);
      check("t1_valid_n1", 64'(rsp_valid_o), 64'd0);
      tick();
      check("t1_valid_n1b", 64'(rsp_valid_o), 64'd0);
      tick();
      check("t1_valid_n2", 64'(rsp_valid_o), 64'd1);
      check("t1_data",     64'(rsp_data_o),  64'hA5);
      check("t1_wr_cnt",   64'(wr_cnt_o),    64'd1);
      check("t1_rd_cnt",   64'(rd_cnt_o),    64'd1);
      rsp_ready_i = 1'b1;
      drain("t1");

      // 2: preload 0..7 with addr+0x10, then 8 back-to-back reads
      for (int a = 0; a < 8; a++) send(1'b1, AWIDTH'(a), DWIDTH'(a + 16));
      pops0 = n_pop;
      first_pop_cyc = -1;
      for (int a = 0; a < 8; a++) send(1'b0, AWIDTH'(a), '0);
      drain("t2");
      check("t2_pops",    64'(n_pop - pops0),                64'd8);
      check("t2_1_per_cyc", 64'(last_pop_cyc - first_pop_cyc), 64'd7);
      check("t2_wr_cnt",  64'(wr_cnt_o), 64'd9);
      check("t2_rd_cnt",  64'(rd_cnt_o), 64'd9);

      // 3: credit limit with a stalled consumer
      rsp_ready_i = 1'b0;
      pops0 = n_pop;
      nacc = 0;
      req_valid_i = 1'b1;
      req_write_i = 1'b0;
      req_addr_i  = '0;
      for (int i = 0; i < 8; i++) begin
         tick();
         if (acc) begin
            nacc++;
            req_addr_i = req_addr_i + 1'b1;
         end
      end
      check("t3_accepted_stalled", 64'(nacc), 64'd4);
      check("t3_ready_low",        64'(req_ready_o), 64'd0);
      rsp_ready_i = 1'b1;
      for (int i = 0; i < 20 && nacc < 6; i++) begin
         tick();
         if (acc) begin
            nacc++;
            req_addr_i = req_addr_i + 1'b1;
            if (nacc == 6) req_valid_i = 1'b0;
         end
      end
      req_valid_i = 1'b0;
      check("t3_accepted_total", 64'(nacc), 64'd6);
      drain("t3");
      check("t3_pops", 64'(n_pop - pops0), 64'd6);

      // 4: stray rddatavalid
      force_rdv = 1'b1;
      tick();
      force_rdv = 1'b0;
      tick();
      check("t4_err_set",    64'(err_o),              64'd1);
      check("t4_fifo_count", 64'(dut.u_fifo.count),   64'd0);
      check("t4_no_rsp",     64'(rsp_valid_o),        64'd0);
      tick();
      tick();
      check("t4_err_sticky", 64'(err_o), 64'd1);

      // 5: reset with two reads in flight
      rsp_ready_i = 1'b1;
      send(1'b0, 8'h05, '0);
      send(1'b0, 8'h06, '0);
      #2;
      rst_ni = 1'b0;
      #1;
      check_all_zero("t5_reset");
      #2;
      rst_ni = 1'b1;
      exp_q.delete();
      @(posedge clk);
      #1;
      check("t5_err_after",  64'(err_o),       64'd0);
      check("t5_no_stale",   64'(rsp_valid_o), 64'd0);
      pops0 = n_pop;
      tick();
      tick();
      tick();
      check("t5_no_stale_later", 64'(n_pop - pops0), 64'd0);
      check("t5_err_later",      64'(err_o),          64'd0);
      send(1'b0, 8'h01, '0);
      drain("t5");
      check("t5_pops",   64'(n_pop - pops0), 64'd1);
      check("t5_rd_cnt", 64'(rd_cnt_o),      64'd1);

      // 6: simultaneous push and pop at count 3
      rsp_ready_i = 1'b0;
      send(1'b0, 8'h00, '0);
      send(1'b0, 8'h01, '0);
      send(1'b0, 8'h02, '0);
      for (int i = 0; i < 10 && dut.u_fifo.count != 3'd3; i++) tick();
      check("t6_count_pre", 64'(dut.u_fifo.count), 64'd3);
      send(1'b0, 8'h03, '0);
      tick();
      rsp_ready_i = 1'b1;
      check("t6_count_before", 64'(dut.u_fifo.count), 64'd3);
      check("t6_head_before",  64'(rsp_data_o),       64'h10);
      tick();
      check("t6_count_after",  64'(dut.u_fifo.count), 64'd3);
      check("t6_head_after",   64'(rsp_data_o),       64'h11);
      drain("t6");
      check("final_rd_cnt", 64'(rd_cnt_o), 64'd5);
      check("final_wr_cnt", 64'(wr_cnt_o), 64'd0);
      check("final_err",    64'(err_o),    64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
